// File: rtl/qact_leakyrelu_stream.sv
// Multi-lane quantised activation stage (BYPASS / RELU / LEAKY) with per-frame config latch.
// Three-stage valid/ready pipeline: S1 capture, S2 re-centre + activate, S3 re-add zero + clamp.
module qact_leakyrelu_stream #(
    parameter int CH  = 8,
    parameter int DW  = 8,
    parameter int SHW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [SHW-1:0]    cfg_shift,
    input  logic [DW-1:0]     cfg_zero,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CH*DW-1:0]  s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH*DW-1:0]  m_data,
    output logic              m_last,
    output logic [15:0]       frame_cnt
);

    localparam int unsigned WD = DW + 2;
    localparam logic [1:0] MODE_RELU  = 2'd1;
    localparam logic [1:0] MODE_LEAKY = 2'd2;

    logic              armed;
    logic [1:0]        cap_mode;
    logic [SHW-1:0]    cap_shift;
    logic [DW-1:0]     cap_zero;

    logic              s1_valid;
    logic              s1_last;
    logic [CH*DW-1:0]  s1_q;
    logic [1:0]        s1_mode;
    logic [SHW-1:0]    s1_shift;
    logic [DW-1:0]     s1_zero;

    logic              s2_valid;
    logic              s2_last;
    logic [CH*WD-1:0]  s2_d;
    logic [DW-1:0]     s2_zero;

    logic              s1_free;
    logic              s2_free;
    logic              s3_free;
    logic              accept;
    logic [1:0]        eff_mode;
    logic [SHW-1:0]    eff_shift;
    logic [DW-1:0]     eff_zero;
    logic [CH*WD-1:0]  s2_next;
    logic [CH*DW-1:0]  s3_next;

    // A stage may load when it is empty or its contents move on this cycle
    assign s3_free  = !m_valid || m_ready;
    assign s2_free  = !s2_valid || s3_free;
    assign s1_free  = !s1_valid || s2_free;
    assign s_ready  = !rst && s1_free;
    assign accept   = s_valid && s_ready;

    // First beat of a frame takes live config; later beats use the captured copy
    assign eff_mode  = armed ? cfg_mode  : cap_mode;
    assign eff_shift = armed ? cfg_shift : cap_shift;
    assign eff_zero  = armed ? cfg_zero  : cap_zero;

    for (genvar i = 0; i < CH; i++) begin : g_lane
        logic signed [WD-1:0] diff;
        logic signed [WD-1:0] shr;
        logic signed [WD-1:0] act;
        logic signed [WD-1:0] sum;
        logic [DW-1:0]        res;

        assign diff = $signed({2'b00, s1_q[i*DW +: DW]}) - $signed({2'b00, s1_zero});
        assign shr  = diff >>> s1_shift;

        always_comb begin
            act = diff;
            if (diff[WD-1]) begin
                if (s1_mode == MODE_RELU) begin
                    act = '0;
                end else if (s1_mode == MODE_LEAKY) begin
                    act = shr;
                end
            end
        end

        assign sum = $signed(s2_d[i*WD +: WD]) + $signed({2'b00, s2_zero});

        // Saturate to the unsigned lane range
        always_comb begin
            res = sum[DW-1:0];
            if (sum[WD-1]) begin
                res = '0;
            end else if (sum[DW]) begin
                res = '1;
            end
        end

        assign s2_next[i*WD +: WD] = act;
        assign s3_next[i*DW +: DW] = res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed     <= 1'b1;
            cap_mode  <= '0;
            cap_shift <= '0;
            cap_zero  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_q      <= '0;
            s1_mode   <= '0;
            s1_shift  <= '0;
            s1_zero   <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_d      <= '0;
            s2_zero   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (accept) begin
                armed <= s_last;
                if (armed) begin
                    cap_mode  <= cfg_mode;
                    cap_shift <= cfg_shift;
                    cap_zero  <= cfg_zero;
                end
            end

            if (s1_free) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_q     <= s_data;
                    s1_last  <= s_last;
                    s1_mode  <= eff_mode;
                    s1_shift <= eff_shift;
                    s1_zero  <= eff_zero;
                end
            end

            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_d    <= s2_next;
                    s2_zero <= s1_zero;
                    s2_last <= s1_last;
                end
            end

            if (s3_free) begin
                m_valid <= s2_valid;
                if (s2_valid) begin
                    m_data <= s3_next;
                    m_last <= s2_last;
                end
            end

            if (m_valid && m_ready && m_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_qact_leakyrelu_stream.sv
// Directed self-checking bench for qact_leakyrelu_stream (CH=8, DW=8, SHW=3).
// Expected lane values are hand-computed constants or pass-through identities.
module tb_qact_leakyrelu_stream;

    logic        clk;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [2:0]  cfg_shift;
    logic [7:0]  cfg_zero;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic [15:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    logic [63:0] st_data [16];
    logic [63:0] st_exp  [16];
    logic        st_last [16];
    logic [1:0]  st_mode [16];
    int          st_n;
    int          st_stall_from;
    int          st_stall_to;

    qact_leakyrelu_stream #(.CH(8), .DW(8), .SHW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_mode  (cfg_mode),
        .cfg_shift (cfg_shift),
        .cfg_zero  (cfg_zero),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3,
                                       input logic [7:0] a4, input logic [7:0] a5,
                                       input logic [7:0] a6, input logic [7:0] a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-beat frame: accept, check exact 3-cycle latency, let it drain
    task automatic run1(input string tag, input logic [1:0] mode, input logic [2:0] shift,
                        input logic [7:0] zero, input logic [63:0] q, input logic [63:0] exp);
        cfg_mode  = mode;
        cfg_shift = shift;
        cfg_zero  = zero;
        s_valid   = 1'b1;
        s_data    = q;
        s_last    = 1'b1;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        step();
        chk({tag, "_early"}, 64'(m_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(m_valid), 64'd1);
        chk({tag, "_data"}, m_data, exp);
        chk({tag, "_last"}, 64'(m_last), 64'd1);
        exp_frames++;
        step();
    endtask

    // Cycle-driven stream with optional m_ready stall window and in-order scoreboard
    task automatic run_stream(input string tag);
        int sent = 0;
        int recv = 0;
        logic stalled = 1'b0;
        logic [63:0] held = '0;
        logic acc;
        logic emit;
        for (int cyc = 0; cyc < 80 && recv < st_n; cyc++) begin
            m_ready = !(cyc >= st_stall_from && cyc <= st_stall_to);
            s_valid = (sent < st_n);
            if (sent < st_n) begin
                s_data   = st_data[sent];
                s_last   = st_last[sent];
                cfg_mode = st_mode[sent];
            end else begin
                s_data = '0;
                s_last = 1'b0;
            end
            #1;
            chk({tag, "_s_ready"}, 64'(s_ready), 64'(!((sent - recv) == 3 && !m_ready)));
            if (stalled) begin
                chk({tag, "_hold_valid"}, 64'(m_valid), 64'd1);
                chk({tag, "_hold_data"}, m_data, held);
            end
            if (recv > 0 && m_ready) chk({tag, "_no_gap"}, 64'(m_valid), 64'd1);
            acc  = s_valid && s_ready;
            emit = m_valid && m_ready;
            if (emit) begin
                chk({tag, "_data"}, m_data, st_exp[recv]);
                chk({tag, "_last"}, 64'(m_last), 64'(st_last[recv]));
                if (st_last[recv]) exp_frames++;
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
            step();
            if (acc) sent++;
            if (emit) recv++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        chk({tag, "_all_beats"}, 64'(recv), 64'(st_n));
    endtask

    initial begin
        logic [63:0] q;
        rst       = 1'b1;
        cfg_mode  = 2'd0;
        cfg_shift = 3'd0;
        cfg_zero  = 8'd0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        step();
        step();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        step();

        // LEAKY shift 3, z=128
        run1("t1_leaky", 2'd2, 3'd3, 8'd128,
             pk(64, 200, 128, 0, 255, 127, 120, 136),
             pk(120, 200, 128, 112, 255, 127, 127, 136));
        chk("t1_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // RELU, BYPASS and reserved mode with z=128
        q = pk(100, 128, 129, 0, 255, 130, 127, 1);
        run1("t2_relu", 2'd1, 3'd3, 8'd128, q, pk(128, 128, 129, 128, 255, 130, 128, 128));
        run1("t2_bypass", 2'd0, 3'd3, 8'd128, q, q);
        run1("t2_reserved", 2'd3, 3'd3, 8'd128, q, q);

        // Identity cases: shift=0 with any z, or z=0 with any shift
        for (int i = 0; i < 256; i++) begin
            q = {$urandom(), $urandom()};
            if (i % 2 == 0) run1("t3_shift0", 2'd2, 3'd0, 8'($urandom_range(0, 255)), q, q);
            else            run1("t3_zero0", 2'd2, 3'($urandom_range(0, 7)), 8'd0, q, q);
        end
        run1("t3_floor", 2'd2, 3'd7, 8'd255,
             pk(0, 255, 254, 1, 128, 127, 0, 200),
             pk(253, 255, 254, 253, 254, 254, 253, 254));
        chk("t3_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // 10-beat BYPASS frame with m_ready low for 5 cycles mid-stream
        cfg_shift = 3'd2;
        cfg_zero  = 8'd77;
        st_n = 10;
        st_stall_from = 5;
        st_stall_to   = 9;
        for (int i = 0; i < 10; i++) begin
            st_data[i] = {$urandom(), $urandom()};
            st_exp[i]  = st_data[i];
            st_last[i] = (i == 9);
            st_mode[i] = 2'd0;
        end
        run_stream("t4_stall");
        chk("t4_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // Reset with two beats of a LEAKY frame in flight
        cfg_mode  = 2'd2;
        cfg_shift = 3'd3;
        cfg_zero  = 8'd128;
        s_valid   = 1'b1;
        s_last    = 1'b0;
        s_data    = pk(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t6_s_ready", 64'(s_ready), 64'd0);
        step();
        rst = 1'b0;
        exp_frames = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t6_no_stale", 64'(m_valid), 64'd0);
            step();
        end

        // Frame A (RELU, 4 beats, cfg flips to LEAKY on beat 2) then frame B (LEAKY, 3 beats)
        cfg_shift = 3'd1;
        cfg_zero  = 8'd128;
        st_n = 7;
        st_stall_from = 1000;
        st_stall_to   = 1000;
        for (int i = 0; i < 7; i++) begin
            st_data[i] = pk(100, 200, 128, 0, 50, 150, 127, 10);
            st_exp[i]  = (i < 4) ? pk(128, 200, 128, 128, 128, 150, 128, 128)
                                 : pk(114, 200, 128, 64, 89, 150, 127, 69);
            st_last[i] = (i == 3 || i == 6);
            st_mode[i] = (i == 0) ? 2'd1 : 2'd2;
        end
        run_stream("t5_frames");
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
